// File: rtl/reg_dump_uart.sv
// Walks the register file debug index list, captures each 40-bit {data, tag} word and sends it as 5 UART 8N1 bytes.
// Latency: 10 x (5 + 50 x CLKS_PER_BIT) cycles from START sample to DONE; no backpressure, START is ignored while BUSY.
module reg_dump_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_ENTRIES  = 10
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [39:0] R_OUT,
    output logic [4:0]  INC,
    output logic        CLK_INC,
    output logic        TX,
    output logic        BUSY,
    output logic        DONE
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  PTR_LAST  = 4'(NUM_ENTRIES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SEL, S_STROBE, S_WAIT, S_CAPTURE,
        S_TX_START, S_TX_DATA, S_TX_STOP, S_NEXT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [2:0]  byte_q, byte_d;
    logic [2:0]  bit_q, bit_d;
    logic [15:0] baud_q, baud_d;
    logic [39:0] cap_q, cap_d;
    logic [4:0]  inc_q, inc_d;
    logic        baud_end;
    logic [7:0]  cur_byte;

    function automatic logic [4:0] idx_lut(input logic [3:0] p);
        case (p)
            4'd0:    idx_lut = 5'd2;
            4'd1:    idx_lut = 5'd3;
            4'd2:    idx_lut = 5'd4;
            4'd3:    idx_lut = 5'd5;
            4'd4:    idx_lut = 5'd6;
            4'd5:    idx_lut = 5'd12;
            4'd6:    idx_lut = 5'd13;
            4'd7:    idx_lut = 5'd14;
            4'd8:    idx_lut = 5'd15;
            default: idx_lut = 5'd16;
        endcase
    endfunction

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            byte_q  <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
            cap_q   <= '0;
            inc_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            cap_q   <= cap_d;
            inc_q   <= inc_d;
        end
    end

    assign baud_end = (baud_q == BAUD_LAST);

    // Tag goes first on the wire, then register data MSB byte down.
    always_comb begin
        case (byte_q)
            3'd0:    cur_byte = cap_q[7:0];
            3'd1:    cur_byte = cap_q[39:32];
            3'd2:    cur_byte = cap_q[31:24];
            3'd3:    cur_byte = cap_q[23:16];
            default: cur_byte = cap_q[15:8];
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        cap_d   = cap_q;
        inc_d   = inc_q;
        baud_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_SEL;
                    ptr_d   = '0;
                    inc_d   = idx_lut(4'd0);
                end
            end
            S_SEL:     state_d = S_STROBE;
            S_STROBE:  state_d = S_WAIT;
            // WAIT gives the register file one cycle to settle R_OUT after the strobe.
            S_WAIT:    state_d = S_CAPTURE;
            S_CAPTURE: begin
                cap_d   = R_OUT;
                byte_d  = '0;
                state_d = S_TX_START;
            end
            S_TX_START: begin
                baud_d = baud_end ? '0 : baud_q + 16'd1;
                if (baud_end) begin
                    state_d = S_TX_DATA;
                    bit_d   = '0;
                end
            end
            S_TX_DATA: begin
                baud_d = baud_end ? '0 : baud_q + 16'd1;
                if (baud_end) begin
                    if (bit_q == 3'd7) state_d = S_TX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            S_TX_STOP: begin
                baud_d = baud_end ? '0 : baud_q + 16'd1;
                if (baud_end) begin
                    if (byte_q < 3'd4) begin
                        byte_d  = byte_q + 3'd1;
                        state_d = S_TX_START;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (ptr_q < PTR_LAST) begin
                    ptr_d   = ptr_q + 4'd1;
                    inc_d   = idx_lut(ptr_q + 4'd1);
                    state_d = S_SEL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        INC     = inc_q;
        CLK_INC = (state_q == S_STROBE);
        BUSY    = (state_q != S_IDLE);
        DONE    = (state_q == S_NEXT) && (ptr_q == PTR_LAST);
        case (state_q)
            S_TX_START: TX = 1'b0;
            S_TX_DATA:  TX = cur_byte[bit_q];
            default:    TX = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_reg_dump_uart.sv
// Scoreboard bench for reg_dump_uart: expected strobes, bytes and DONE timing are queued at stimulus time and popped by monitors.
module tb_reg_dump_uart;
    localparam int CPB       = 4;
    localparam int DUMP_CYCS = 10 * (5 + 50 * CPB);

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic [39:0] R_OUT;
    logic [4:0]  INC;
    logic        CLK_INC, TX, BUSY, DONE;

    reg_dump_uart #(.CLKS_PER_BIT(CPB), .NUM_ENTRIES(10)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .R_OUT(R_OUT),
        .INC(INC), .CLK_INC(CLK_INC), .TX(TX), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_bytes[$];
    logic [4:0] exp_inc[$];
    int         exp_done[$];
    logic [4:0] idx_tab [10] = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};

    bit          special = 1'b0;
    bit          cap_mode = 1'b0;
    logic [39:0] r_model = '0;
    logic [39:0] r_alt = '0;
    assign R_OUT = cap_mode ? r_alt : r_model;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [39:0] reg_word(input logic [4:0] i, input bit sp);
        logic [31:0] d;
        if (sp && i == 5'd2) return {32'hDEADBEEF, 8'h01};
        d = 32'h11111111 * {27'b0, i};
        return {d, 3'b000, i};
    endfunction

    function automatic logic [39:0] cap_word(input int e);
        logic [31:0] hi;
        logic [7:0]  lo;
        hi = 32'hCAFE0000 + 32'(e);
        lo = 8'hA0 + 8'(e);
        return {hi, lo};
    endfunction

    task automatic push_word(input logic [39:0] w, input int nbytes);
        logic [7:0] b [5];
        b[0] = w[7:0]; b[1] = w[39:32]; b[2] = w[31:24]; b[3] = w[23:16]; b[4] = w[15:8];
        for (int k = 0; k < nbytes; k++) exp_bytes.push_back(b[k]);
    endtask

    task automatic push_dump(input bit sp, input bit capw);
        for (int e = 0; e < 10; e++) begin
            exp_inc.push_back(idx_tab[e]);
            push_word(capw ? cap_word(e) : reg_word(idx_tab[e], sp), 5);
        end
        exp_done.push_back(DUMP_CYCS);
    endtask

    // Register file model: updates its debug word on the strobe's rising edge.
    always @(posedge CLK_INC) r_model <= reg_word(INC, special);

    // Capture-window driver: garbage every cycle except the CAPTURE cycle (two cycles after STROBE).
    int since = 100, cap_e = 0, cap_cur = 0;
    always @(posedge CLK) begin
        #1;
        if (!cap_mode) begin
            cap_e = 0;
            since = 100;
        end else begin
            if (CLK_INC) begin
                since = 0;
                cap_cur = cap_e;
                cap_e++;
            end else if (since < 100) since++;
            r_alt = (since == 2) ? cap_word(cap_cur) : {32'($urandom), 8'($urandom)};
        end
    end

    // Strobe and DONE monitor.
    int busy_cnt = 0, done_cnt = 0, inc_cnt = 0;
    always @(negedge CLK) begin
        if (CLK_INC) begin
            inc_cnt++;
            if (exp_inc.size() == 0) chk("inc_unexpected", longint'(INC), 0);
            else chk("inc_index", longint'(INC), longint'(exp_inc.pop_front()));
        end
        if (BUSY) busy_cnt++;
        else busy_cnt = 0;
        if (DONE) begin
            done_cnt++;
            if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
            else chk("done_cycles", busy_cnt, exp_done.pop_front());
        end
    end

    // UART decoder: samples once per cycle, mid-bit for data, every cycle for start/stop.
    bit         in_frame = 1'b0, bad = 1'b0;
    int         kk = 0, rx_count = 0;
    logic [7:0] rx_sh = '0;
    always @(negedge CLK) begin
        if (!RESET) in_frame = 1'b0;
        else begin
            if (!in_frame && TX == 1'b0) begin
                in_frame = 1'b1;
                kk = 0;
                bad = 1'b0;
            end
            if (in_frame) begin
                if (kk / CPB == 0 && TX != 1'b0) bad = 1'b1;
                if (kk / CPB >= 1 && kk / CPB <= 8 && kk % CPB == CPB / 2) rx_sh[kk / CPB - 1] = TX;
                if (kk / CPB == 9 && TX != 1'b1) bad = 1'b1;
                if (kk == 10 * CPB - 1) begin
                    in_frame = 1'b0;
                    rx_count++;
                    chk("uart_frame", longint'(bad), 0);
                    if (exp_bytes.size() == 0) chk("uart_unexpected_byte", longint'(rx_sh), -1);
                    else chk("uart_byte", longint'(rx_sh), longint'(exp_bytes.pop_front()));
                end else kk++;
            end
        end
    end

    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < DUMP_CYCS + 100 && done_cnt < n; i++) @(negedge CLK);
        chk("done_timeout", longint'(done_cnt >= n), 1);
    endtask

    initial begin
        int dev, base;
        repeat (3) @(negedge CLK);
        chk("rst_tx", longint'(TX), 1);
        chk("rst_busy", longint'(BUSY), 0);
        chk("rst_done", longint'(DONE), 0);
        chk("rst_clk_inc", longint'(CLK_INC), 0);
        chk("rst_inc", longint'(INC), 0);
        RESET = 1'b1;
        dev = 0;
        repeat (100) begin
            @(negedge CLK);
            if (TX !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0 || CLK_INC !== 1'b0 || INC !== 5'd0) dev++;
        end
        chk("idle_stable", dev, 0);

        // Full dump with the DEADBEEF word on the first entry.
        special = 1'b1;
        push_dump(1'b1, 1'b0);
        base = rx_count;
        pulse_start();
        wait_done(1);
        repeat (5) @(negedge CLK);
        chk("dump1_bytes", rx_count - base, 50);
        chk("dump1_strobes", inc_cnt, 10);
        chk("dump1_idle_busy", longint'(BUSY), 0);
        chk("dump1_inc_hold", longint'(INC), 16);

        // START re-pulsed mid-dump is ignored.
        special = 1'b0;
        push_dump(1'b0, 1'b0);
        base = rx_count;
        pulse_start();
        repeat (600) @(negedge CLK);
        pulse_start();
        wait_done(2);
        repeat (50) @(negedge CLK);
        chk("dump2_bytes", rx_count - base, 50);
        chk("dump2_done_once", done_cnt, 2);
        chk("dump2_strobes", inc_cnt, 20);

        // Reset during byte 2 of entry 3.
        for (int e = 0; e < 4; e++) begin
            exp_inc.push_back(idx_tab[e]);
            push_word(reg_word(idx_tab[e], 1'b0), (e < 3) ? 5 : 2);
        end
        base = rx_count;
        pulse_start();
        for (int i = 0; i < DUMP_CYCS && rx_count < base + 17; i++) @(negedge CLK);
        chk("mid_reach_byte", rx_count - base, 17);
        repeat (3 * CPB) @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        chk("mid_rst_tx", longint'(TX), 1);
        chk("mid_rst_busy", longint'(BUSY), 0);
        chk("mid_rst_inc", longint'(INC), 0);
        repeat (20) @(negedge CLK);
        chk("mid_inc_left", exp_inc.size(), 0);
        chk("mid_bytes_left", exp_bytes.size(), 0);
        RESET = 1'b1;
        @(negedge CLK);
        push_dump(1'b0, 1'b0);
        base = rx_count;
        pulse_start();
        wait_done(3);
        repeat (5) @(negedge CLK);
        chk("restart_bytes", rx_count - base, 50);

        // R_OUT only matters in the CAPTURE cycle.
        cap_mode = 1'b1;
        @(negedge CLK);
        push_dump(1'b0, 1'b1);
        base = rx_count;
        pulse_start();
        wait_done(4);
        repeat (5) @(negedge CLK);
        chk("cap_bytes", rx_count - base, 50);
        chk("final_bytes_left", exp_bytes.size(), 0);
        chk("final_done_left", exp_done.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
